// File: rtl/ceespu_dmem_ctrl_if.sv
// Signal bundle between the ceespu core dmem port, the data-memory controller and the word bus.
// Names are as seen from the controller: I_* are controller inputs, O_* are controller outputs.
interface ceespu_dmem_ctrl_if #(
  parameter int ADDR_WIDTH = 16
);
  // Core side
  logic [ADDR_WIDTH-1:0] I_dmemAddress;
  logic [31:0]           I_dmemWData;
  logic                  I_dmemE;
  logic [3:0]            I_dmemWe;
  logic [31:0]           O_dmemData;
  logic                  O_dmemBusy;

  // Bus side: the controller holds O_busReq high until an I_busAck edge (or an abort).
  // Address, data and strobes stay constant for as long as O_busReq is high.
  // Read data on I_busRData is valid in the same cycle as I_busAck.
  logic [ADDR_WIDTH-3:0] O_busAddr;
  logic [31:0]           O_busWData;
  logic [3:0]            O_busWe;
  logic                  O_busReq;
  logic                  I_busAck;
  logic [31:0]           I_busRData;
  logic                  O_busErr;

  // Current controller state, 0=IDLE 1=RD 2=WR
  logic [1:0]            O_dbgState;

  modport slave (
    input  I_dmemAddress, I_dmemWData, I_dmemE, I_dmemWe, I_busAck, I_busRData,
    output O_dmemData, O_dmemBusy, O_busAddr, O_busWData, O_busWe, O_busReq,
           O_busErr, O_dbgState
  );

  modport master (
    output I_dmemAddress, I_dmemWData, I_dmemE, I_dmemWe, I_busAck, I_busRData,
    input  O_dmemData, O_dmemBusy, O_busAddr, O_busWData, O_busWe, O_busReq,
           O_busErr, O_dbgState
  );
endinterface

// File: rtl/ceespu_dmem_ctrl.sv
// ceespu data-memory controller: posted one-entry writes, stalled reads over a req/ack word bus.
// Optional bus timeout with sticky error flag is enabled by defining CEESPU_DMEM_TIMEOUT_EN.
module ceespu_dmem_ctrl #(
  parameter int          ADDR_WIDTH     = 16,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
  input logic               I_clk,
  input logic               I_rst,
  ceespu_dmem_ctrl_if.slave dmem
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  w_accept;
  logic                  w_active;
  logic                  w_abort;
  logic [ADDR_WIDTH-3:0] r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_we;
  logic [31:0]           r_rdata;
  logic                  r_err;
  logic                  w_unused;

  // Busy is decoded from the state register alone so the core never sees a comb loop.
  assign w_active = (r_state != ST_IDLE);
  assign w_accept = (r_state == ST_IDLE) && dmem.I_dmemE;

`ifdef CEESPU_DMEM_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CW-1:0] r_cnt;

  // The count holds the number of unacked req cycles already elapsed; an ack on the limit edge wins.
  assign w_abort = w_active && !dmem.I_busAck && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (w_active && !dmem.I_busAck) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      r_err <= 1'b0;
    end else if (w_abort) begin
      r_err <= 1'b1;
    end
  end

  assign w_unused = ^dmem.I_dmemAddress[1:0];
`else
  assign w_abort  = 1'b0;
  assign r_err    = 1'b0;
  assign w_unused = ^{dmem.I_dmemAddress[1:0], ERR_DATA, 32'(TIMEOUT_CYCLES)};
`endif

  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = (dmem.I_dmemWe != 4'b0000) ? ST_WR : ST_RD;
        end
      end
      ST_RD, ST_WR: begin
        if (dmem.I_busAck || w_abort) begin
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Capture registers double as the bus drive, so the bus sees them stable for the whole request.
  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= '0;
    end else if (w_accept) begin
      r_addr <= dmem.I_dmemAddress[ADDR_WIDTH-1:2];
      r_we   <= dmem.I_dmemWe;
      if (dmem.I_dmemWe != 4'b0000) begin
        r_wdata <= dmem.I_dmemWData;
      end
    end
  end

  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      r_rdata <= '0;
    end else if ((r_state == ST_RD) && dmem.I_busAck) begin
      r_rdata <= dmem.I_busRData;
`ifdef CEESPU_DMEM_TIMEOUT_EN
    end else if ((r_state == ST_RD) && w_abort) begin
      r_rdata <= ERR_DATA;
`endif
    end
  end

  assign dmem.O_dmemData = r_rdata;
  assign dmem.O_dmemBusy = w_active;
  assign dmem.O_busReq   = w_active;
  assign dmem.O_busAddr  = r_addr;
  assign dmem.O_busWData = r_wdata;
  assign dmem.O_busWe    = r_we;
  assign dmem.O_busErr   = r_err;
  assign dmem.O_dbgState = r_state;

endmodule

// File: doc/ceespu_dmem_ctrl.md
Name: ceespu_dmem_ctrl

Overview:
Data-memory controller directly downstream of the ceespu core's dmem port. It consumes the core's address, write-data, enable and byte-write-enable signals, and produces read data and the busy stall signal. Toward a slower word-addressed memory bus it runs a req/ack handshake. Writes are posted through a one-entry buffer; reads stall the core until the bus acknowledges.

Parameters:
ADDR_WIDTH, 16, core byte-address width; bus word address is ADDR_WIDTH-2 bits
TIMEOUT_CYCLES, 255, bus wait limit before abort (only with the optional feature)
ERR_DATA, 32'hDEADBEEF, read data returned on abort (only with the optional feature)

Ports:
I_clk  in  1  clock, rising edge
I_rst  in  1  asynchronous, active-low reset
I_dmemAddress  in  ADDR_WIDTH  core byte address
I_dmemWData  in  32  core write data
I_dmemE  in  1  core access request
I_dmemWe  in  4  byte write enables; 0 means read
O_dmemData  out  32  read data to core
O_dmemBusy  out  1  stall to core
O_busAddr  out  ADDR_WIDTH-2  word address (I_dmemAddress[ADDR_WIDTH-1:2])
O_busWData  out  32  write data
O_busWe  out  4  byte strobes; 0 means read
O_busReq  out  1  bus request
I_busAck  in  1  bus acknowledge; read data valid in the same cycle
I_busRData  in  32  bus read data
O_busErr  out  1  sticky timeout flag (tied 0 when the optional feature is absent)

Behaviour:
- Reset (I_rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0.
  - A pending posted write is discarded; O_busReq drops immediately, without waiting for a clock edge.
- States are IDLE, RD and WR. O_dmemBusy = (state != IDLE), decoded from the state register only, with no input path.
- IDLE, accept rule: a request is accepted at a rising edge where I_dmemE=1 and O_dmemBusy=0.
  - Accepted with I_dmemWe != 0: capture address, data and strobes; go to WR. The core is not stalled on this access, only on its next memory access while WR persists.
  - Accepted with I_dmemWe == 0: capture the address; go to RD.
  - I_dmemAddress[1:0] is ignored.
- RD and WR:
  - O_busReq=1, with O_busAddr, O_busWData and O_busWe held stable from the captured registers.
  - At a rising edge where I_busAck=1: go to IDLE. In RD, also load O_dmemData from I_busRData.
  - O_busReq is 0 for at least one cycle between transactions.
- Latency:
  - Read, ack in the first req cycle: core presents the read at edge N, busy is high in cycle N+1, and data and busy=0 appear after edge N+1. That is one stall cycle.
  - Write: zero stall cycles when the next core access comes no earlier than the cycle after ack.
- O_dmemData holds the last read value until the next completed read; writes do not alter it.
- Boundary conditions:
  - I_busAck while IDLE is ignored.
  - Core request held during busy is accepted on the first edge with busy=0, i.e. the cycle after the completing ack.
  - I_dmemE with no bus activity and a held address re-issues the access; each accepted edge is a new transaction.
  - Bus word address wraps naturally at 2^(ADDR_WIDTH-2); there is no special handling.

Optional Feature:
Macro: CEESPU_DMEM_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entering RD or WR and increments each cycle without ack.
  - When the count reaches TIMEOUT_CYCLES with no ack, go to IDLE, drop req, and set O_busErr=1 (sticky until reset).
  - In RD, O_dmemData=ERR_DATA. In WR, the write is dropped.
  - An ack on the same edge as the limit wins: normal completion, no error.
- Not defined: no counter; the controller waits for ack indefinitely; O_busErr is constant 0.

Test Plan:
- Read, immediate ack: core read of addr 16'h0010, bus acks in the first req cycle with 32'h12345678 -> O_busAddr=14'h0004, O_busWe=0, busy high exactly 1 cycle, O_dmemData=32'h12345678.
- Posted write: core write addr 16'h0022, data 32'hAABBCCDD, We=4'b0011 -> O_busAddr=14'h0008, O_busWe=4'b0011; busy low at acceptance and high in the following cycles until ack; ack after 3 cycles -> IDLE.
- Read behind a write: write then read 1 cycle later, write ack delayed 4 cycles -> read accepted the cycle after write ack; req low for 1 cycle between the two transactions.
- Reset mid-read: assert I_rst=0 while in RD with no clock edge -> O_busReq and O_dmemBusy drop immediately; O_dmemData=0; a later ack is ignored.
- Stray ack: I_busAck=1 while IDLE with I_busRData=32'hFFFFFFFF -> O_dmemData unchanged, no state change.
- With CEESPU_DMEM_TIMEOUT_EN and TIMEOUT_CYCLES=4: read, never ack -> abort after 4 cycles, O_dmemData=32'hDEADBEEF, O_busErr=1 and remains 1 through later good transactions.
